demux_1a4_16bits: RTL
=====================

DEMUX_1A4_16BITS -- requirements
Module: demux_1a4_16bits

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of every data path.
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port IN_DATA  input  DATA_W  upstream word.
REQ-005 The block SHALL have port IN_SEL  input  2  destination channel for IN_DATA: 0=A, 1=B, 2=C, 3=D.
REQ-006 The block SHALL have port IN_VALID  input  1  upstream word and IN_SEL are valid.
REQ-007 The block SHALL have port IN_READY  output  1  block accepts the word this cycle.
REQ-008 The block SHALL have ports OUT_A, OUT_B, OUT_C, OUT_D  output  DATA_W  per-channel held words.
REQ-009 The block SHALL have ports VALID_A..VALID_D  output  1 each  per-channel word-present flags.
REQ-010 The block SHALL have ports READY_A..READY_D  input  1 each  per-channel downstream accept.

Function
REQ-011 A transfer SHALL occur upstream when IN_VALID && IN_READY, and on channel x when VALID_x && READY_x.
REQ-012 Each channel SHALL hold one word in a slot with two states: EMPTY (VALID_x=0) and FULL (VALID_x=1).
REQ-013 An accepted word SHALL load the slot selected by IN_SEL at the same edge; VALID_x SHALL go high the next cycle (latency 1).
REQ-014 IN_READY SHALL be combinational: 1 when the slot selected by IN_SEL is EMPTY, or FULL with READY_x=1 this cycle.
REQ-015 IN_READY SHALL NOT depend on IN_VALID.
REQ-016 EMPTY->FULL SHALL occur on a load without a drain; FULL->EMPTY on a drain without a load; a simultaneous load and drain SHALL keep the slot FULL with the new word.
REQ-017 OUT_x SHALL remain stable while VALID_x=1 and READY_x=0.
REQ-018 OUT_x SHALL retain its last word after a drain; its value is don't-care while VALID_x=0.
REQ-019 Only the slot addressed by IN_SEL SHALL be loaded; the other three slots drain independently in the same cycle.
REQ-020 A blocked channel SHALL stall only the upstream words addressed to it; no reordering or dropping of words SHALL occur.

Reset
REQ-021 RST_N=0 SHALL immediately force all slots EMPTY: VALID_A..D=0 and OUT_A..D=0.
REQ-022 Reset asserted mid-transfer SHALL discard all held words, and no partial load SHALL survive.
REQ-023 After RST_N deasserts, IN_READY SHALL be 1 for any IN_SEL.

Configuration
REQ-024 With macro DEMUX_BROADCAST_EN defined, the block SHALL add input IN_BCAST (1 bit).
REQ-025 With DEMUX_BROADCAST_EN defined and IN_BCAST=1, IN_SEL SHALL be ignored.
REQ-026 With DEMUX_BROADCAST_EN defined and IN_BCAST=1, IN_READY SHALL require all four slots to be EMPTY or draining this cycle.
REQ-027 With DEMUX_BROADCAST_EN defined, an accepted IN_BCAST=1 word SHALL load all four slots at one edge.
REQ-028 Without DEMUX_BROADCAST_EN, the IN_BCAST port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-011..REQ-020.

Structure
REQ-029 The shared package SHALL hold the DATA_W default 16, the channel count 4, the 2-bit channel encoding constants CH_A..CH_D, and the slot state enum {EMPTY, FULL}.
REQ-030 The block SHALL instantiate sub-module demux_slot four times; each instance is a one-word holding register with load, drain, valid and data ports.

Verification
REQ-031 Reset, then IN_SEL=2, IN_DATA=16'hBEEF, IN_VALID=1 for one cycle -> next cycle VALID_C=1, OUT_C=16'hBEEF, other VALIDs 0.
REQ-032 READY_A=0, two words 16'h0001 and 16'h0002 to SEL=0 -> first word accepted, IN_READY=0 on the second, OUT_A holds 16'h0001; raise READY_A -> 16'h0002 loads on the same edge as the drain.
REQ-033 READY_B=0 with slot B FULL, then a word 16'h1234 to SEL=3 -> IN_READY=1, VALID_D=1 next cycle, slot B unchanged.
REQ-034 Slots A and D FULL, RST_N pulsed low between clock edges -> VALID_A=VALID_D=0 and OUT_A=OUT_D=0 immediately.
REQ-035 Streaming to SEL=0,1,2,3 with all READYs=1 -> one word per cycle with IN_READY=1 throughout, in order, latency 1.
REQ-036 With DEMUX_BROADCAST_EN defined, slot C FULL, READY_C=0, IN_BCAST=1, IN_DATA=16'hA5A5 -> IN_READY=0; raise READY_C -> all four OUT_x=16'hA5A5 next cycle.

Source files
------------

// File: rtl/demux_1a4_16bits_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: default data width,
// channel count, 2-bit channel codes and the per-channel slot state.
// No ports. Optional feature macro used by the top: DEMUX_BROADCAST_EN.
package demux_1a4_16bits_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int NUM_CH     = 4;

  // IN_SEL encoding
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1a4_16bits_slot.sv
// Purpose : one-word holding register for a single demux output channel.
// Latency : 1 cycle from load_i to valid_o; drain frees the slot at the same edge.
// Backpres: free_o is high when empty or draining this cycle, so a load can overlap a drain.
// Ports   : clk_i/rst_n_i (async active-low), load_i + data_i (write),
//           drain_rdy_i (downstream ready), valid_o/data_o (held word), free_o.
module demux_slot
  import demux_1a4_16bits_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              drain_rdy_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over drain: a simultaneous load+drain keeps the slot FULL with
  // the new word. The data register is only written on a load, so the last
  // word stays visible after a drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = FULL;
      data_d  = data_i;
    end else if ((state_q == FULL) && drain_rdy_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign free_o  = (state_q == EMPTY) || drain_rdy_i;

endmodule

// File: rtl/demux_1a4_16bits.sv
// Purpose : routes one upstream word per cycle into one of four one-word channel slots.
// Latency : 1 cycle from accepted IN_DATA to VALID_x/OUT_x.
// Backpres: IN_READY is combinational from the addressed slot (empty or draining);
//           a blocked channel stalls only words addressed to it.
// Ports   : CLK, RST_N (async active-low); IN_DATA/IN_SEL/IN_VALID/IN_READY upstream;
//           OUT_x/VALID_x/READY_x per channel A..D.
// Macro   : DEMUX_BROADCAST_EN adds IN_BCAST, which writes all four slots at once.
module demux_1a4_16bits
  import demux_1a4_16bits_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [1:0]        IN_SEL,
  input  logic              IN_VALID,
`ifdef DEMUX_BROADCAST_EN
  input  logic              IN_BCAST,
`endif
  output logic              IN_READY,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B,
  output logic [DATA_W-1:0] OUT_C,
  output logic [DATA_W-1:0] OUT_D,
  output logic              VALID_A,
  output logic              VALID_B,
  output logic              VALID_C,
  output logic              VALID_D,
  input  logic              READY_A,
  input  logic              READY_B,
  input  logic              READY_C,
  input  logic              READY_D
);

  logic [NUM_CH-1:0] rdy_vec;
  logic [NUM_CH-1:0] vld_vec;
  logic [NUM_CH-1:0] free_vec;
  logic [NUM_CH-1:0] sel_vec;
  logic [NUM_CH-1:0] load_vec;
  logic [DATA_W-1:0] dat_arr [NUM_CH];

  assign rdy_vec = {READY_D, READY_C, READY_B, READY_A};

  // One-hot target mask; broadcast targets every slot and ignores IN_SEL.
  always_comb begin
    sel_vec         = '0;
    sel_vec[IN_SEL] = 1'b1;
`ifdef DEMUX_BROADCAST_EN
    if (IN_BCAST) begin
      sel_vec = '1;
    end
`endif
  end

  // Ready depends only on the targeted slots, never on IN_VALID.
`ifdef DEMUX_BROADCAST_EN
  assign IN_READY = IN_BCAST ? (&free_vec) : free_vec[IN_SEL];
`else
  assign IN_READY = free_vec[IN_SEL];
`endif

  assign load_vec = sel_vec & {NUM_CH{IN_VALID && IN_READY}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i       (CLK),
      .rst_n_i     (RST_N),
      .load_i      (load_vec[g]),
      .data_i      (IN_DATA),
      .drain_rdy_i (rdy_vec[g]),
      .valid_o     (vld_vec[g]),
      .data_o      (dat_arr[g]),
      .free_o      (free_vec[g])
    );
  end

  assign OUT_A   = dat_arr[CH_A];
  assign OUT_B   = dat_arr[CH_B];
  assign OUT_C   = dat_arr[CH_C];
  assign OUT_D   = dat_arr[CH_D];
  assign VALID_A = vld_vec[CH_A];
  assign VALID_B = vld_vec[CH_B];
  assign VALID_C = vld_vec[CH_C];
  assign VALID_D = vld_vec[CH_D];

endmodule
